// File: rtl/data_mem_mmio_pkg.sv
// data_mem_mmio_pkg: register map, bit positions and timer control layout
package data_mem_mmio_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_LOAD   = 8'h04;
  localparam logic [7:0] OFF_COUNT  = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_TXDATA = 8'h10;
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int ST_EXPIRED  = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_OVERFLOW = 3;
  localparam int ST_OCC_LSB  = 8;
  localparam int ST_OCC_W    = 4;
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;
endpackage

// File: rtl/data_mem_mmio_tx_fifo.sv
// tx_fifo: circular byte queue that accepts a push while full if a pop frees a slot
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage is not reset; only slots behind the pointers are ever visible
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: core data port decode to word RAM or timer/TX-FIFO registers
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int          MEM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] MMIO_TAG   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_adr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0] ram [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [7:0] off;
  logic mmio, wr_mmio, wr_ctrl, wr_load, wr_status, wr_tx;
  ctrl_t ctrl;
  logic [31:0] load, count, status, reg_rdata;
  logic expired, overflow, zero, fire, pop;
  logic fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic unused;
  assign unused    = ^data_adr;
  assign mmio      = data_adr[31:16] == MMIO_TAG;
  assign off       = data_adr[7:0];
  assign idx       = data_adr[AW+1:2];
  assign wr_mmio   = MemWrite & mmio;
  assign wr_ctrl   = wr_mmio & (off == OFF_CTRL);
  assign wr_load   = wr_mmio & (off == OFF_LOAD);
  assign wr_status = wr_mmio & (off == OFF_STATUS);
  assign wr_tx     = wr_mmio & (off == OFF_TXDATA);
  assign zero      = count == '0;
  assign fire      = ctrl.en & zero;
  assign pop       = tx_valid & tx_ready;
  assign tx_valid  = ~fifo_empty;
  assign irq       = expired & ctrl.irq_en;
  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst(rst), .push(wr_tx), .push_data(wdata[7:0]), .pop(pop),
    .head(tx_data), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  // RAM store path; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && MemWrite && !mmio) ram[idx] <= wdata;
  end
  // timer and sticky status; software writes beat hardware updates except expiry set
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl     <= '0;
      load     <= '0;
      count    <= '0;
      expired  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_t'(wdata[2:0]);
      else if (fire && !ctrl.auto_reload) ctrl.en <= 1'b0;
      if (wr_load) load <= wdata;
      if (wr_load) count <= wdata;
      else if (ctrl.en) count <= !zero ? count - 1'b1 : ctrl.auto_reload ? load : count;
      expired  <= fire | (expired & ~(wr_status & wdata[ST_EXPIRED]));
      overflow <= (wr_tx & fifo_full & ~pop) | (overflow & ~(wr_status & wdata[ST_OVERFLOW]));
    end
  end
  // register read mux and load data steering
  always_comb begin
    status = '0;
    status[ST_EXPIRED]  = expired;
    status[ST_TX_FULL]  = fifo_full;
    status[ST_TX_EMPTY] = fifo_empty;
    status[ST_OVERFLOW] = overflow;
    status[ST_OCC_LSB +: ST_OCC_W] = ST_OCC_W'(fifo_count);
    reg_rdata = off == OFF_CTRL   ? {29'b0, ctrl} :
                off == OFF_LOAD   ? load :
                off == OFF_COUNT  ? count :
                off == OFF_STATUS ? status : '0;
    rdata = !MemRead ? '0 : mmio ? reg_rdata : ram[idx];
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed checks of RAM, timer, TX FIFO and reset behaviour
module tb_data_mem_mmio;
  localparam logic [31:0] A_CTRL   = 32'hFFFF0000;
  localparam logic [31:0] A_LOAD   = 32'hFFFF0004;
  localparam logic [31:0] A_COUNT  = 32'hFFFF0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF000C;
  localparam logic [31:0] A_TXDATA = 32'hFFFF0010;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] data_adr = '0, wdata = '0, rdata;
  logic MemRead = 1'b0, MemWrite = 1'b0, tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid, irq;
  int vectors = 0, miscompares = 0;
  logic [31:0] r;

  data_mem_mmio dut (
    .clk(clk), .rst(rst), .data_adr(data_adr), .wdata(wdata), .MemRead(MemRead),
    .MemWrite(MemWrite), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    data_adr = a;
    wdata = d;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_adr = a;
    MemRead = 1'b1;
    #1;
    d = rdata;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", irq); end
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h4) begin miscompares++; $display("FAIL reset_status got %h exp 00000004", r); end
    rd(A_CTRL, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL reset_ctrl got %h exp 00000000", r); end
  endtask

  task automatic test_ram();
    wr(32'h00000040, 32'hDEADBEEF);
    rd(32'h00000040, r);
    vectors++; if (r !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_read got %h exp deadbeef", r); end
    data_adr = 32'h00000040;
    #1;
    vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL ram_noread got %h exp 00000000", rdata); end
    rd(32'h00000440, r);
    vectors++; if (r !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_alias got %h exp deadbeef", r); end
    data_adr = 32'h00000040;
    wdata = 32'h12345678;
    MemRead = 1'b1;
    MemWrite = 1'b1;
    #1;
    vectors++; if (rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ram_rw_prewrite got %h exp deadbeef", rdata); end
    tick();
    MemWrite = 1'b0;
    #1;
    vectors++; if (rdata !== 32'h12345678) begin miscompares++; $display("FAIL ram_rw_after got %h exp 12345678", rdata); end
    MemRead = 1'b0;
    rd(32'hFFFF0020, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL mmio_unmapped got %h exp 00000000", r); end
    rd(A_TXDATA, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL mmio_txdata_wo got %h exp 00000000", r); end
  endtask

  task automatic test_oneshot();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 4; i++) begin
      rd(A_COUNT, r);
      vectors++; if (r !== 32'(3 - i)) begin miscompares++; $display("FAIL oneshot_count[%0d] got %0d exp %0d", i, r, 3 - i); end
      if (i < 3) tick();
    end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_irq_early got %b exp 0", irq); end
    tick();
    rd(A_STATUS, r);
    vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("FAIL oneshot_expired got %b exp 1", r[0]); end
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL oneshot_irq got %b exp 1", irq); end
    rd(A_CTRL, r);
    vectors++; if (r !== 32'h4) begin miscompares++; $display("FAIL oneshot_ctrl got %h exp 00000004", r); end
    tick();
    rd(A_COUNT, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL oneshot_hold got %0d exp 0", r); end
    wr(A_STATUS, 32'h1);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL oneshot_irq_clear got %b exp 0", irq); end
  endtask

  task automatic test_autoreload();
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < 9; i++) begin
      rd(A_COUNT, r);
      vectors++; if (r !== 32'(2 - (i % 3))) begin miscompares++; $display("FAIL reload_count[%0d] got %0d exp %0d", i, r, 2 - (i % 3)); end
      rd(A_STATUS, r);
      vectors++; if (r[0] !== (i >= 3)) begin miscompares++; $display("FAIL reload_expired[%0d] got %b exp %b", i, r[0], i >= 3); end
      tick();
    end
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h4) begin miscompares++; $display("FAIL reload_stop_status got %h exp 00000004", r); end
  endtask

  task automatic test_fifo_overflow();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_TXDATA, 32'h11 + i);
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h80A) begin miscompares++; $display("FAIL fifo_full_status got %h exp 0000080a", r); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h11 + i)) begin miscompares++; $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(8'h11 + i)); end
      tick();
    end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL drain_done got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h4) begin miscompares++; $display("FAIL overflow_clear got %h exp 00000004", r); end
  endtask

  task automatic test_full_with_pop();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'h21 + i);
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h802) begin miscompares++; $display("FAIL fwp_full_status got %h exp 00000802", r); end
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'hAA);
    for (int i = 0; i < 8; i++) begin
      vectors++; if (tx_valid !== 1'b1 || tx_data !== (i < 7 ? 8'(8'h22 + i) : 8'hAA)) begin miscompares++; $display("FAIL fwp_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, (i < 7 ? 8'(8'h22 + i) : 8'hAA)); end
      tick();
    end
    tx_ready = 1'b0;
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h4) begin miscompares++; $display("FAIL fwp_no_overflow got %h exp 00000004", r); end
  endtask

  task automatic test_reset_midrun();
    wr(A_LOAD, 32'd100);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h31 + i);
    vectors++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin miscompares++; $display("FAIL pre_rst_fifo got v=%b d=%h exp v=1 d=31", tx_valid, tx_data); end
    rst = 1'b1;
    data_adr = A_TXDATA;
    wdata = 32'h99;
    MemWrite = 1'b1;
    tick();
    rst = 1'b0;
    MemWrite = 1'b0;
    rd(A_COUNT, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", r); end
    vectors++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_fifo got v=%b d=%h exp v=0 d=00", tx_valid, tx_data); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rst_irq got %b exp 0", irq); end
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h4) begin miscompares++; $display("FAIL rst_status got %h exp 00000004", r); end
    tick();
    rd(A_COUNT, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL rst_timer_idle got %0d exp 0", r); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_ram();
    test_oneshot();
    test_autoreload();
    test_fifo_overflow();
    test_full_with_pop();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle MIPS core's data port.
- Consumes the core's data_adr, write data, MemRead and MemWrite, and returns read data in the same cycle.
- Decodes each access to a word RAM region or a memory-mapped I/O region.
- The MMIO region holds a programmable down-counter timer and an 8-bit transmit FIFO that drains over a valid/ready stream.

Parameters:
- MEM_WORDS, 256, RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 8, TX FIFO entries (power of 2, at least 2).
- MMIO_TAG, 16'hFFFF, value of data_adr[31:16] that selects MMIO.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_adr  input  32  byte address from core; word aligned, bits [1:0] ignored.
- wdata  input  32  store data from core (core's data_out).
- MemRead  input  1  read strobe.
- MemWrite  input  1  write strobe.
- rdata  output  32  load data to core (core's data_in); combinational.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  sink accepts the head byte this cycle.
- irq  output  1  timer interrupt, equal to expired AND CTRL.irq_en.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values:
  - timer ctrl = 0, load = 0, count = 0.
  - expired = 0, overflow = 0.
  - FIFO empty, pointers = 0.
  - Resulting outputs: tx_valid = 0, tx_data = 0, irq = 0.
  - RAM contents are not reset.
- Decode: MMIO when data_adr[31:16] == MMIO_TAG; otherwise RAM word index data_adr[$clog2(MEM_WORDS)+1:2]. Upper RAM address bits alias.
- Reads:
  - rdata is combinational with zero latency.
  - rdata = 0 when MemRead = 0, for unmapped MMIO offsets, and for write-only registers.
  - Reads have no side effects.
- Writes: take effect at the clk edge where MemWrite = 1. If MemRead and MemWrite are both 1, the write takes effect and rdata shows the pre-write value.
- MMIO offsets (data_adr[7:0]):
  - 0x00 CTRL, RW: bit0 en, bit1 auto_reload, bit2 irq_en. Other bits read 0.
  - 0x04 LOAD, RW: 32 bits. A write also sets count = wdata in the same edge.
  - 0x08 COUNT, RO.
  - 0x0C STATUS, R/W1C:
    - bit0 expired (W1C); bit3 overflow (W1C).
    - bit1 tx_full (RO); bit2 tx_empty (RO).
    - bits[11:8] fifo occupancy (RO).
  - 0x10 TXDATA, WO: pushes wdata[7:0].
- Timer:
  - While en = 1 and count != 0: count decrements by 1 per cycle.
  - When en = 1 and count == 0: expired is set.
    - auto_reload = 1: count = load on that edge.
    - auto_reload = 0: en is cleared and count holds 0.
  - Unsigned 32-bit count, no wrap below 0.
- Timer simultaneous events:
  - A LOAD write overrides decrement or reload in the same cycle.
  - A CTRL write overrides the hardware en-clear.
  - When expiry and a W1C of expired occur in the same cycle, the set wins.
- FIFO:
  - tx_data is the head entry, or 0 when empty.
  - Pop occurs when tx_valid and tx_ready are both 1.
  - Push on a TXDATA write is accepted when occupancy < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Simultaneous push and pop on an empty FIFO: the push is accepted and there is no pop.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy width is $clog2(FIFO_DEPTH)+1.
- Reset mid-operation: rst overrides any concurrent write, pop or count. Outputs reach reset values in the cycle after the rst edge.

Decomposition:
- Package data_mem_mmio_pkg holds:
  - MMIO offset constants (CTRL, LOAD, COUNT, STATUS, TXDATA).
  - STATUS and CTRL bit-index constants.
  - A typedef struct for the timer CTRL fields.
- One sub-module, tx_fifo (parameter DEPTH, WIDTH = 8), provides:
  - push, push_data, pop, head, full, empty, count.
  - The accept-on-full-with-pop rule.
- Timer and decode stay in the top module.

Test Plan:
- RAM: write 0xDEADBEEF to 0x00000040, then MemRead the same address -> rdata = 0xDEADBEEF in the same cycle; read with MemRead = 0 -> rdata = 0.
- One-shot timer:
  - Stimulus: LOAD = 3, then CTRL = 0x5.
  - COUNT reads 3, 2, 1, 0 on successive cycles.
  - expired = 1 and irq = 1 on the cycle after count reaches 0; CTRL.en reads 0.
  - Write STATUS = 0x1 -> irq = 0.
- Auto-reload: LOAD = 2, CTRL = 0x3, run 9 cycles -> expired set at each count = 0; count returns to 2.
- FIFO fill and overflow:
  - With tx_ready = 0, push 0x11..0x19 (9 bytes).
  - STATUS shows full = 1, occupancy = 8, overflow = 1.
  - With tx_ready = 1, bytes drain 0x11..0x18 in order; tx_valid drops after 8 cycles.
- Full with simultaneous pop: FIFO full, tx_ready = 1, push 0xAA in the same cycle -> accepted, no overflow; 0xAA is the last byte out.
- Reset mid-run: timer counting and FIFO holding 3 bytes; assert rst for one cycle -> COUNT = 0, tx_valid = 0, irq = 0, STATUS = 0x4.
